// File: rtl/vec_iter_ctrl_if.sv
// Vector-iteration handshake bundle.
// Purpose : carries the input vector handshake, the result handshake and the
//           per-iteration direction bits between a producer/consumer and
//           vec_iter_ctrl.
// Signals : in_valid/in_ready/in_X/in_Y   input vector channel
//           out_valid/out_ready/out_X/out_Y/sign_seq   result channel
// Modports: master = producer/consumer side, slave = vec_iter_ctrl side.
interface vec_iter_ctrl_if #(
    parameter int unsigned DATA_LENGTH = 13,
    parameter int unsigned NUM_ITER    = 12
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_LENGTH-1:0] in_X;
    logic signed [DATA_LENGTH-1:0] in_Y;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [DATA_LENGTH-1:0] out_X;
    logic signed [DATA_LENGTH-1:0] out_Y;
    logic        [NUM_ITER-1:0]    sign_seq;

    modport master (
        output in_valid, in_X, in_Y, out_ready,
        input  in_ready, out_valid, out_X, out_Y, sign_seq
    );

    modport slave (
        input  in_valid, in_X, in_Y, out_ready,
        output in_ready, out_valid, out_X, out_Y, sign_seq
    );
endinterface

// File: rtl/vec_iter_ctrl.sv
// CORDIC vectoring controller.
// Purpose : accepts one (X,Y) vector, rotates it onto the X axis with NUM_ITER
//           micro-rotations (two per clock), and presents the magnitude
//           estimate, residual Y and the direction bit of every micro-rotation.
// Ports   : clk, rst_n (async, active-low)
//           bus (vec_iter_ctrl_if.slave) input/result handshakes and data
// Config  : define VEC_GAIN_COMP_EN to add a one-cycle GAIN state that scales
//           out_X by ~0.607 to cancel the CORDIC gain.
module vec_iter_ctrl #(
    parameter int unsigned DATA_LENGTH = 13,
    parameter int unsigned NUM_ITER    = 12,
    parameter int unsigned CNT_W       = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    vec_iter_ctrl_if.slave bus
);
    localparam int unsigned   DL       = DATA_LENGTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ITER - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_GAIN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic signed [DL-1:0]   x_q, x_d, y_q, y_d;
    logic [NUM_ITER-1:0]    sgn_q, sgn_d;
    logic signed [DL-1:0]   out_x_q, out_y_q;
    logic [NUM_ITER-1:0]    out_sgn_q;
    logic                   in_ready_q, out_valid_q;
    logic                   load_out;

    // Two chained micro-rotations per cycle, shifts cnt_q and cnt_q+1.
    logic [CNT_W-1:0]       sh1;
    logic                   d0, d1;
    logic signed [DL-1:0]   x1, y1, x2, y2;
    logic [NUM_ITER-1:0]    sgn_iter;

    always_comb begin
        sh1 = cnt_q + CNT_W'(1);
        d0  = x_q[DL-1] ^ y_q[DL-1];
        x1  = d0 ? (x_q - (y_q >>> cnt_q)) : (x_q + (y_q >>> cnt_q));
        y1  = d0 ? (y_q + (x_q >>> cnt_q)) : (y_q - (x_q >>> cnt_q));
        d1  = x1[DL-1] ^ y1[DL-1];
        x2  = d1 ? (x1 - (y1 >>> sh1)) : (x1 + (y1 >>> sh1));
        y2  = d1 ? (y1 + (x1 >>> sh1)) : (y1 - (x1 >>> sh1));
        sgn_iter = sgn_q;
        for (int k = 0; k < int'(NUM_ITER); k++) begin
            if (CNT_W'(k) == cnt_q) sgn_iter[k] = d0;
            if (CNT_W'(k) == sh1)   sgn_iter[k] = d1;
        end
    end

`ifdef VEC_GAIN_COMP_EN
    // K ~= 1/2 + 1/8 - 1/64 - 1/512 ~= 0.607
    logic signed [DL-1:0] gain_x;
    always_comb begin
        gain_x = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        sgn_d    = sgn_q;
        load_out = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.in_X;
                    y_d     = bus.in_Y;
                    sgn_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                x_d   = x2;
                y_d   = y2;
                sgn_d = sgn_iter;
                cnt_d = cnt_q + CNT_W'(2);
                if (cnt_q == LAST_CNT) begin
`ifdef VEC_GAIN_COMP_EN
                    state_d  = ST_GAIN;
`else
                    state_d  = ST_DONE;
                    load_out = 1'b1;
`endif
                end
            end
`ifdef VEC_GAIN_COMP_EN
            ST_GAIN: begin
                x_d      = gain_x;
                state_d  = ST_DONE;
                load_out = 1'b1;
            end
`endif
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Working state and FSM register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sgn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sgn_q   <= sgn_d;
        end
    end

    // Result registers only change on entry to DONE so the consumer never
    // sees intermediate iterations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_sgn_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (load_out) begin
                out_x_q   <= x_d;
                out_y_q   <= y_d;
                out_sgn_q <= sgn_d;
            end
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_X     = out_x_q;
    assign bus.out_Y     = out_y_q;
    assign bus.sign_seq  = out_sgn_q;
endmodule

// File: tb/tb_vec_iter_ctrl.sv
// Testbench for vec_iter_ctrl: directed and random vectors against an
// arithmetic reference model of the vectoring rules.
module tb_vec_iter_ctrl;
    localparam int unsigned DL = 13;
    localparam int unsigned NI = 12;
    localparam int unsigned CW = 4;
`ifdef VEC_GAIN_COMP_EN
    localparam int GAIN_CYC = 1;
`else
    localparam int GAIN_CYC = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vec_iter_ctrl_if #(.DATA_LENGTH(DL), .NUM_ITER(NI)) bus ();

    vec_iter_ctrl #(.DATA_LENGTH(DL), .NUM_ITER(NI), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap(input int v);
        logic signed [DL-1:0] t;
        t = DL'(v);
        return int'(t);
    endfunction

    // Apply the micro-rotation rule NUM_ITER times with wrapped arithmetic.
    function automatic void ref_model(input int xi, input int yi,
                                      output int xo, output int yo, output longint sg);
        int x, y, xn, yn;
        x = xi; y = yi; sg = 0;
        for (int s = 0; s < int'(NI); s++) begin
            if ((x < 0) != (y < 0)) begin
                xn = wrap(x - (y >>> s));
                yn = wrap(y + (x >>> s));
                sg = sg | (longint'(1) << s);
            end else begin
                xn = wrap(x + (y >>> s));
                yn = wrap(y - (x >>> s));
            end
            x = xn; y = yn;
        end
`ifdef VEC_GAIN_COMP_EN
        x = wrap((x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9));
`endif
        xo = x; yo = y;
    endfunction

    function automatic int rnd_comp();
        return int'($urandom_range(4800)) - 2400;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One full transaction: accept, latency, hold during ITER, result, stall, release.
    task automatic run_one(input int x, input int y, input int hold, input string tag);
        int ex, ey, cyc;
        longint es, px, py, ps;
        bit stable, dn_ok;
        ref_model(x, y, ex, ey, es);
        cyc = 0;
        while (!bus.in_ready && cyc < 40) begin tick(); cyc++; end
        check_eq({tag, "_in_ready"}, longint'(bus.in_ready), 1);
        px = longint'(bus.out_X); py = longint'(bus.out_Y); ps = longint'(bus.sign_seq);
        bus.in_valid = 1'b1;
        bus.in_X = DL'(x);
        bus.in_Y = DL'(y);
        tick();
        bus.in_valid = 1'b0;
        cyc = 0; stable = 1'b1;
        while (!bus.out_valid && cyc < 40) begin
            if (longint'(bus.out_X) != px || longint'(bus.out_Y) != py ||
                longint'(bus.sign_seq) != ps || bus.in_ready) stable = 1'b0;
            tick();
            cyc++;
        end
        check_eq({tag, "_latency"}, cyc, NI / 2 + GAIN_CYC);
        check_eq({tag, "_iter_hold"}, stable, 1);
        check_eq({tag, "_out_x"}, longint'(bus.out_X), ex);
        check_eq({tag, "_out_y"}, longint'(bus.out_Y), ey);
        check_eq({tag, "_sign"}, longint'(bus.sign_seq), es);
        dn_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.in_X = DL'(rnd_comp());
            bus.in_Y = DL'(rnd_comp());
            tick();
            if (longint'(bus.out_X) != ex || longint'(bus.out_Y) != ey ||
                longint'(bus.sign_seq) != es || !bus.out_valid || bus.in_ready) dn_ok = 1'b0;
        end
        bus.in_valid = 1'b0;
        if (hold > 0) check_eq({tag, "_done_hold"}, dn_ok, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq({tag, "_rel_valid"}, longint'(bus.out_valid), 0);
        check_eq({tag, "_rel_ready"}, longint'(bus.in_ready), 1);
    endtask

    initial begin : main
        int ex, ey, cyc, last_acc, n_got;
        longint es;
        bit late, acc;
        int qx[$];
        int qy[$];
        longint qs[$];

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_X = '0; bus.in_Y = '0;
        #12;
        check_eq("rst_out_valid", longint'(bus.out_valid), 0);
        check_eq("rst_in_ready", longint'(bus.in_ready), 1);
        check_eq("rst_out_x", longint'(bus.out_X), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // (100,0): first two directions are 0 then 1, residual Y small.
        run_one(100, 0, 0, "x100");
        check_eq("x100_sign10", longint'(bus.sign_seq[1:0]), 2);
        check_eq("x100_y_small", longint'(iabs(int'(bus.out_Y)) <= 2), 1);

        run_one(0, 0, 0, "zero");
        check_eq("zero_all", longint'(bus.out_X == 0 && bus.out_Y == 0 && bus.sign_seq == 0), 1);

        run_one(-300, 400, 5, "neg");
        check_eq("neg_sign0", longint'(bus.sign_seq[0]), 1);

        run_one(2400, -2400, 1, "edge_pm");
        run_one(-2400, -2400, 0, "edge_mm");
        for (int t = 0; t < 12; t++) run_one(rnd_comp(), rnd_comp(), int'($urandom_range(3)), "rnd");

        // Reset in the middle of ITER discards the transaction.
        bus.in_valid = 1'b1; bus.in_X = DL'(50); bus.in_Y = DL'(60);
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", longint'(bus.out_valid), 0);
        check_eq("mid_rst_x", longint'(bus.out_X), 0);
        check_eq("mid_rst_y", longint'(bus.out_Y), 0);
        check_eq("mid_rst_sign", longint'(bus.sign_seq), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check_eq("post_rst_ready", longint'(bus.in_ready), 1);
        late = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) late = 1'b1;
        end
        check_eq("post_rst_no_result", late, 0);

        // Back-to-back: in_valid and out_ready held high.
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_X = DL'(rnd_comp()); bus.in_Y = DL'(rnd_comp());
        last_acc = -1; n_got = 0;
        for (int c = 0; c < 200 && n_got < 5; c++) begin
            if (bus.out_valid) begin
                if (qx.size() > 0) begin
                    check_eq("b2b_x", longint'(bus.out_X), qx.pop_front());
                    check_eq("b2b_y", longint'(bus.out_Y), qy.pop_front());
                    check_eq("b2b_sign", longint'(bus.sign_seq), qs.pop_front());
                end else begin
                    check_eq("b2b_unexpected", 1, 0);
                end
                n_got++;
            end
            acc = bus.in_ready;
            if (acc) begin
                ref_model(int'(bus.in_X), int'(bus.in_Y), ex, ey, es);
                qx.push_back(ex); qy.push_back(ey); qs.push_back(es);
                if (last_acc >= 0) check_eq("b2b_period", c - last_acc, NI / 2 + 2 + GAIN_CYC);
                last_acc = c;
            end
            tick();
            if (acc) begin
                bus.in_X = DL'(rnd_comp());
                bus.in_Y = DL'(rnd_comp());
            end
        end
        check_eq("b2b_count", n_got, 5);
        bus.in_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin tick(); cyc++; end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
